// File: rtl/button_press_gen.sv
// button_press_gen: synthesises short/long button presses on a single line.
// Each sequence is N presses (N latched at start, 0 treated as 1). Every press
// is a steady high of SHORT_CYC or LONG_CYC cycles followed by a REL_CYC low gap.
// A start/busy/done handshake frames the sequence. All outputs are registered.
//
// Optional feature macro: BUTTON_PRESS_GEN_BOUNCE_EN
//   defined   - each press is preceded by BOUNCE_PULSES glitches (BNC_CYC high,
//               BNC_CYC low) to exercise downstream synchronisers/debouncers.
//   undefined - clean rectangular presses; the bounce knobs are ignored.
module button_press_gen #(
  parameter int CLK_PERIOD_ns  = 20,
  parameter int SHORT_PRESS_ns = 100,
  parameter int LONG_PRESS_ns  = 500,
  parameter int RELEASE_ns     = 200,
  parameter int BOUNCE_ns      = 40,
  parameter int BOUNCE_PULSES  = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       long,
  input  logic [3:0] repeats,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int SHORT_CYC = SHORT_PRESS_ns / CLK_PERIOD_ns;
  localparam int LONG_CYC  = LONG_PRESS_ns / CLK_PERIOD_ns;
  localparam int REL_CYC   = RELEASE_ns / CLK_PERIOD_ns;

`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  localparam int BNC_CYC   = BOUNCE_ns / CLK_PERIOD_ns;
  // Half-periods are numbered 0..HALF_LAST; even halves drive high.
  localparam int HALF_LAST = 2 * BOUNCE_PULSES - 1;
  localparam int HALF_W    = (HALF_LAST > 0) ? $clog2(HALF_LAST + 1) : 1;
  localparam int MAX_LR    = (LONG_CYC > REL_CYC) ? LONG_CYC : REL_CYC;
  localparam int MAX_CYC   = (MAX_LR > BNC_CYC) ? MAX_LR : BNC_CYC;
`else
  localparam int MAX_CYC   = (LONG_CYC > REL_CYC) ? LONG_CYC : REL_CYC;
`endif

  localparam int TMR_W = $clog2(MAX_CYC) + 1;

  // The timer is loaded with (duration - 1) and the phase ends when it reads 0.
  localparam logic [TMR_W-1:0] SHORT_LD = TMR_W'(SHORT_CYC - 1);
  localparam logic [TMR_W-1:0] LONG_LD  = TMR_W'(LONG_CYC - 1);
  localparam logic [TMR_W-1:0] REL_LD   = TMR_W'(REL_CYC - 1);
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  localparam logic [TMR_W-1:0] BNC_LD   = TMR_W'(BNC_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_END = HALF_W'(HALF_LAST);
`endif

  // Elaboration-time sanity checks on the derived cycle counts.
  if (SHORT_CYC < 1) begin : g_chk_short
    $error("button_press_gen: short press must be at least one clock");
  end
  if (LONG_CYC <= SHORT_CYC) begin : g_chk_long
    $error("button_press_gen: long press must be longer than short press");
  end
  if (REL_CYC < 1) begin : g_chk_rel
    $error("button_press_gen: release gap must be at least one clock");
  end
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  if (BNC_CYC < 1 || BOUNCE_PULSES < 1) begin : g_chk_bnc
    $error("button_press_gen: bounce half-period and pulse count must be >= 1");
  end
`else
  if (BOUNCE_ns < 0 || BOUNCE_PULSES < 0) begin : g_chk_bnc
    $error("button_press_gen: bounce knobs must not be negative");
  end
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
    BOUNCE  = 2'd3,
`endif
    RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       rem_q, rem_d;
  logic             long_q, long_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             begin_press;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  logic [HALF_W-1:0] half_q, half_d;
`endif

  // State register plus sequence datapath and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      rem_q   <= '0;
      long_q  <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      half_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      long_q  <= long_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      half_q  <= half_d;
`endif
    end
  end

  // Next-state and datapath: shared down-counting timer drives every phase change.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d     = state_q;
    tmr_d       = tmr_q;
    rem_d       = rem_q;
    long_d      = long_q;
    begin_press = 1'b0;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
    half_d      = half_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          long_d      = long;
          rem_d       = (repeats == 4'd0) ? 4'd1 : repeats;
          begin_press = 1'b1;
        end
      end
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      BOUNCE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (half_q == HALF_END) begin
          state_d = PRESS;
          tmr_d   = long_q ? LONG_LD : SHORT_LD;
        end else begin
          half_d = half_q + 1'b1;
          tmr_d  = BNC_LD;
        end
      end
`endif
      PRESS: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          state_d = RELEASE;
          tmr_d   = REL_LD;
        end
      end
      RELEASE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (rem_q == 4'd1) begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end else begin
          rem_d       = rem_q - 1'b1;
          begin_press = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry into a press, shared by a fresh start and by every repeat.
    if (begin_press) begin
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      state_d = BOUNCE;
      half_d  = '0;
      tmr_d   = BNC_LD;
`else
      state_d = PRESS;
      tmr_d   = long_d ? LONG_LD : SHORT_LD;
`endif
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    out_d  = (state_d == PRESS);
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
    if (state_d == BOUNCE) out_d = ~half_d[0];
`endif
    busy_d = (state_d != IDLE);
    done_d = (state_q == RELEASE) && (tmr_q == '0) && (rem_q == 4'd1);
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/button_press_gen.md
# button_press_gen

Synthesises button-press waveforms on a single output line: a short or long press, repeated a programmable number of times, each followed by a guaranteed release gap. It is the transmit-side counterpart of the long-press detector. It drives press stimulus into detector/synchroniser inputs, or drives external press-sensitive devices, from a start/busy/done handshake.

## Interface
Parameters:
- CLK_PERIOD_ns, 20, clock period used to convert all durations to cycles.
- SHORT_PRESS_ns, 100, high time of a short press (SHORT_CYC = SHORT_PRESS_ns/CLK_PERIOD_ns, integer division, must be ≥1).
- LONG_PRESS_ns, 500, high time of a long press (LONG_CYC, must be > SHORT_CYC).
- RELEASE_ns, 200, low gap after every press (REL_CYC, must be ≥1).
- BOUNCE_ns, 40, half-period of each bounce glitch (BNC_CYC, must be ≥1; used only with the macro).
- BOUNCE_PULSES, 3, number of glitches before the steady press (used only with the macro).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- long  in  1  press type latched at start: 1 = long, 0 = short.
- repeats  in  4  number of presses latched at start; 0 is treated as 1.
- out  out  1  synthesised press line, active high.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse marking sequence completion.

## Operation
- States: IDLE, BOUNCE (macro only), PRESS, RELEASE.
- IDLE: out=0, busy=0. When start=1, the block latches long and repeats, loads the remaining-press counter, and loads the timer. Without the macro it moves to PRESS; with the macro it moves to BOUNCE.
- BOUNCE: out alternates: high for BNC_CYC cycles, then low for BNC_CYC cycles, repeated BOUNCE_PULSES times. After the last low half it moves to PRESS.
- PRESS: out=1 for exactly SHORT_CYC or LONG_CYC cycles, selected by the latched long. Then it moves to RELEASE.
- RELEASE: out=0 for exactly REL_CYC cycles. At expiry the remaining-press counter decrements:
  - if presses remain, go to BOUNCE or PRESS;
  - otherwise go to IDLE with done=1 for that one cycle.
- A single down-counting timer is shared by all states. Its width is $clog2 of the largest cycle count, plus 1.
- start, long and repeats are ignored while busy=1. Input changes after the start cycle have no effect on the sequence in progress.
- All outputs are registered.

## Timing
- Reset values: out=0, busy=0, done=0, state=IDLE, counters cleared.
- Asserting resetn low mid-sequence forces out low immediately (asynchronous) and aborts the sequence. No done pulse is produced.
- start is sampled high at edge t (no macro, press length P, one press):
  - busy=1 from t+1;
  - out=1 for cycles t+1 … t+P;
  - out=0 from t+P+1;
  - done=1 and busy=0 in cycle t+P+REL_CYC+1.
- Each additional repeat adds P+REL_CYC cycles. There is no idle cycle between a release and the next press.
- With the macro, each press is preceded by 2·BNC_CYC·BOUNCE_PULSES bounce cycles, placed before the steady high.
- The done cycle is IDLE. A start in that cycle is accepted, giving a back-to-back sequence with out high again at the next edge.
- done and busy are never high in the same cycle.

## Configuration
- Macro: BUTTON_PRESS_GEN_BOUNCE_EN.
- Defined: the BOUNCE state is compiled in, and every press (including repeats) starts with BOUNCE_PULSES glitches. This exercises the synchroniser and debounce paths of downstream detectors.
- Undefined: the BOUNCE state and its logic are absent, BOUNCE_ns and BOUNCE_PULSES are ignored, and presses are clean rectangular pulses.

## Test plan
All scenarios use default parameters: SHORT_CYC=5, LONG_CYC=25, REL_CYC=10, BNC_CYC=2.
1. Short press, no macro: start=1, long=0, repeats=1 for one cycle → out high exactly 5 cycles; done pulses exactly 16 cycles after start; busy high for 15 cycles.
2. Long press with repeats: long=1, repeats=3 → three 25-cycle highs separated by 10-cycle lows; exactly one done, 106 cycles after start.
3. repeats=0 → identical waveform to repeats=1. A start held high during busy is ignored, then accepted in the done cycle → second press begins on the next edge.
4. Reset mid-sequence: assert resetn=0 at cycle 12 of a long press → out drops asynchronously, busy=0, no done. After release of reset, a new start produces a normal sequence.
5. Macro defined, short press, repeats=1 → out pattern 1,1,0,0 ×3 (12 cycles) then 5 high, 10 low; done pulses 28 cycles after start.
6. Drive out into a long-press detector with a 500 ns threshold → the detector fires only for long=1 presses, never for short presses.
